// File: rtl/hilo_mult_unit.sv
// Iterative 32x32 HI/LO multiplier: one radix-2 shift-add step per clock, sign fix-up at the end.
// Signed operands are reduced to unsigned magnitudes, and the sign is applied to the 64-bit sum.
//
// state | meaning
// IDLE  | waiting for a valid mult/multu start; HI/LO hold
// CALC  | 32 shift-add steps, count 0..31
// FIX   | apply sign, write HI/LO, pulse done next cycle
module hilo_mult_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  alu_op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        rd_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        stall_req
);

   localparam logic [3:0] OP_MULT  = 4'b0110;
   localparam logic [3:0] OP_MULTU = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [63:0] acc_q, acc_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        op_signed;
   logic        op_valid;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] addend;
   logic [63:0] result;

   assign op_signed = (alu_op == OP_MULT);
   assign op_valid  = op_signed || (alu_op == OP_MULTU);

   // 32-bit negation leaves 0x80000000 as 0x80000000, which is the correct unsigned magnitude
   assign mag_a = (op_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
   assign mag_b = (op_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

   assign addend = {32'd0, mcand_q} << cnt_q;
   assign result = neg_q ? (~acc_q + 64'd1) : acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         acc_q    <= 64'd0;
         cnt_q    <= 6'd0;
         neg_q    <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && op_valid) begin
               mcand_d  = mag_a;
               mplier_d = mag_b;
               neg_d    = op_signed & (op_a[31] ^ op_b[31]);
               acc_d    = 64'd0;
               cnt_d    = 6'd0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + addend;
            end
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            hi_d    = result[63:32];
            lo_d    = result[31:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign stall_req = busy & (rd_req | start);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign done      = done_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Bench for hilo_mult_unit: expected products from a behavioural model go into a queue when a
// multiply is issued and are popped when done pulses.
module tb_hilo_mult_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        rd_req;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall_req;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [63:0] prev_res = 64'd0;

   localparam logic [3:0] OP_MULT  = 4'b0110;
   localparam logic [3:0] OP_MULTU = 4'b0111;

   hilo_mult_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .rd_req    (rd_req),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [63:0]        r;
      if (op == OP_MULT) begin
         sa = $signed({{32{a[31]}}, a});
         sb = $signed({{32{b[31]}}, b});
         r  = sa * sb;
      end else begin
         r = {32'd0, a} * {32'd0, b};
      end
      return r;
   endfunction

   // Drives start for exactly one edge (E0) from IDLE; returns at E0 + 1.
   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      alu_op = op;
      op_a   = a;
      op_b   = b;
      exp_q.push_back(model(op, a, b));
      @(posedge clk); #1;
      start  = 1'b0;
      alu_op = 4'd0;
   endtask

   // Counts edges until done is seen (bounded); held reports that HI/LO stayed at the previous
   // result and busy stayed high on every cycle before done.
   task automatic wait_done(output int lat, output bit held);
      lat  = 0;
      held = 1'b1;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
         if ({hi, lo} !== prev_res || busy !== 1'b1) held = 1'b0;
      end
   endtask

   task automatic test_mult_case(input string name, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
      int          lat;
      bit          held;
      logic [63:0] exp;
      start_op(op, a, b);
      wait_done(lat, held);
      checks++;
      if (lat !== 33) begin
         failures++;
         $display("FAIL %s latency: edges_to_done=%0d required=33", name, lat);
      end
      checks++;
      if (held !== 1'b1) begin
         failures++;
         $display("FAIL %s hold: hi/lo or busy disturbed during operation", name);
      end
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard: queue empty", name);
      end else begin
         exp = exp_q.pop_front();
         if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h",
                     name, hi, lo, exp[63:32], exp[31:0]);
         end
         prev_res = exp;
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL %s done_width: done=%b required=0 one cycle later", name, done);
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      start  = 1'b1;
      alu_op = OP_MULT;
      op_a   = 32'h1234_5678;
      op_b   = 32'h0000_0003;
      rd_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_hilo: hi=%h lo=%h required 0", hi, lo);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: busy=%b done=%b required 0", busy, done);
      end
      checks++;
      if (stall_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall: stall_req=%b required 0", stall_req);
      end
      start  = 1'b0;
      alu_op = 4'd0;
      rd_req = 1'b0;
      rst_n  = 1'b1;
   endtask

   task automatic test_invalid_op();
      bit quiet = 1'b1;
      start  = 1'b1;
      alu_op = 4'b0101;
      op_a   = 32'd7;
      op_b   = 32'd9;
      @(posedge clk); #1;
      start  = 1'b0;
      alu_op = 4'd0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL invalid_op_busy: busy=%b required 0", busy);
      end
      repeat (40) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || {hi, lo} !== prev_res) quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1) begin
         failures++;
         $display("FAIL invalid_op_effect: done or hi/lo changed, hi=%h lo=%h", hi, lo);
      end
   endtask

   task automatic test_signed();
      test_mult_case("mult_m2x3", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
      test_mult_case("mult_m1xm1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   task automatic test_min_operand();
      test_mult_case("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000);
      test_mult_case("multu_min", OP_MULTU, 32'h8000_0000, 32'h8000_0000);
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom;
         test_mult_case((i % 2 == 0) ? "rand_mult" : "rand_multu",
                        (i % 2 == 0) ? OP_MULT : OP_MULTU, a, b);
      end
   endtask

   task automatic test_rd_stall();
      int          n  = 0;
      bit          ok = 1'b1;
      logic [63:0] exp;
      start_op(OP_MULT, 32'hFFFF_0001, 32'h0001_2345);
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 5) begin
            rd_req = 1'b1;
            #1;
         end
         if (done) break;
         if (stall_req !== ((n >= 5) ? 1'b1 : 1'b0)) ok = 1'b0;
      end
      checks++;
      if (n !== 33) begin
         failures++;
         $display("FAIL rd_stall_latency: edges_to_done=%0d required=33", n);
      end
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL rd_stall_level: stall_req wrong before done");
      end
      checks++;
      if (stall_req !== 1'b0) begin
         failures++;
         $display("FAIL rd_stall_done: stall_req=%b required 0 in done cycle", stall_req);
      end
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL rd_stall_result: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL rd_stall_result: hi=%h lo=%h required hi=%h lo=%h",
                     hi, lo, exp[63:32], exp[31:0]);
         end
         prev_res = exp;
      end
      rd_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      int          n  = 0;
      int          lat;
      bit          ok = 1'b1;
      bit          held;
      logic [63:0] exp;
      start_op(OP_MULTU, 32'h0001_0003, 32'h0002_0005);
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 10) begin
            start  = 1'b1;
            alu_op = OP_MULT;
            op_a   = 32'hFFFF_FFF9;
            op_b   = 32'h0000_1001;
            #1;
         end
         if (done) break;
         if (n >= 10 && stall_req !== 1'b1) ok = 1'b0;
      end
      checks++;
      if (ok !== 1'b1 || n !== 33) begin
         failures++;
         $display("FAIL b2b_stall: stall_ok=%b edges_to_done=%0d required stall_ok=1 edges=33",
                  ok, n);
      end
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL b2b_first: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL b2b_first: hi=%h lo=%h required hi=%h lo=%h",
                     hi, lo, exp[63:32], exp[31:0]);
         end
         prev_res = exp;
      end
      checks++;
      if (stall_req !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done_stall: stall_req=%b required 0", stall_req);
      end
      exp_q.push_back(model(OP_MULT, 32'hFFFF_FFF9, 32'h0000_1001));
      @(posedge clk); #1;
      start  = 1'b0;
      alu_op = 4'd0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept: busy=%b required 1 after done-cycle start", busy);
      end
      wait_done(lat, held);
      checks++;
      if (lat !== 33 || held !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second_timing: edges_to_done=%0d held=%b required 33 and 1",
                  lat, held);
      end
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL b2b_second: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL b2b_second: hi=%h lo=%h required hi=%h lo=%h",
                     hi, lo, exp[63:32], exp[31:0]);
         end
         prev_res = exp;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      bit quiet = 1'b1;
      start_op(OP_MULT, 32'h7654_3210, 32'hFEDC_BA98);
      repeat (15) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL abort_hilo: hi=%h lo=%h required 0", hi, lo);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_flags: busy=%b done=%b required 0", busy, done);
      end
      exp_q.delete();
      prev_res = 64'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || {hi, lo} !== 64'd0 || busy !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1) begin
         failures++;
         $display("FAIL abort_no_done: done/busy/hi/lo activity after abort, hi=%h lo=%h", hi, lo);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      test_mult_case("post_reset_start", OP_MULTU, 32'h0000_ABCD, 32'h0001_0000);
   endtask

   initial begin
      test_reset();
      test_mult_case("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      test_invalid_op();
      test_signed();
      test_min_operand();
      test_random();
      test_rd_stall();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
